// File: rtl/vc_controller_if.sv
// Bundle for the victim-cache controller: L1 request/response, tag-store command bus,
// writeback port, status and statistics. master = controller side, slave = environment.
interface vc_controller_if #(
  parameter int TAG_WIDTH = 4,
  parameter int NUM_WAYS  = 4
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_op;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 req_dirty;
  logic                 resp_valid;
  logic                 resp_hit;
  logic [WAY_W-1:0]     resp_way;
  logic                 ts_lookup_en;
  logic                 ts_write_en;
  logic                 ts_read_en;
  logic                 ts_valid_clear;
  logic                 ts_dirty_set;
  logic [TAG_WIDTH-1:0] ts_tag;
  logic [WAY_W-1:0]     ts_way;
  logic                 ts_hit;
  logic [WAY_W-1:0]     ts_hit_way;
  logic [NUM_WAYS-1:0]  ts_valid_vector;
  logic [NUM_WAYS-1:0]  ts_dirty_vector;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [WAY_W-1:0]     wb_way;
  logic                 busy;
  logic [15:0]          stat_hits;
  logic [15:0]          stat_misses;
  logic [15:0]          stat_wbs;

  modport master (
    input  req_valid, req_op, req_tag, req_dirty,
    input  ts_hit, ts_hit_way, ts_valid_vector, ts_dirty_vector, wb_ready,
    output req_ready, resp_valid, resp_hit, resp_way,
    output ts_lookup_en, ts_write_en, ts_read_en, ts_valid_clear, ts_dirty_set, ts_tag, ts_way,
    output wb_valid, wb_way, busy, stat_hits, stat_misses, stat_wbs
  );

  modport slave (
    output req_valid, req_op, req_tag, req_dirty,
    output ts_hit, ts_hit_way, ts_valid_vector, ts_dirty_vector, wb_ready,
    input  req_ready, resp_valid, resp_hit, resp_way,
    input  ts_lookup_en, ts_write_en, ts_read_en, ts_valid_clear, ts_dirty_set, ts_tag, ts_way,
    input  wb_valid, wb_way, busy, stat_hits, stat_misses, stat_wbs
  );
endinterface

// File: rtl/vc_controller.sv
// Victim-cache control FSM: tag-store commands, replacement, dirty writebacks, one response per request.
// Optional macro VC_STATS_EN enables 16-bit saturating hit/miss/writeback counters.
module vc_controller #(
  parameter int TAG_WIDTH = 4,
  parameter int NUM_WAYS  = 4
) (
  input logic             clk,
  input logic             rst,
  vc_controller_if.master bus
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DSET   = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  logic [2:0]           r_state;
  logic                 r_op;
  logic                 r_dirty;
  logic                 r_hit;
  logic                 r_use_fifo;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [WAY_W-1:0]     r_way;
  logic [WAY_W-1:0]     r_fifo_ptr;

  logic [WAY_W-1:0]     w_victim;
  logic                 w_all_valid;
  logic                 w_victim_dirty;

  // Lowest-index invalid way wins; with every way valid fall back to the FIFO pointer.
  always_comb begin
    w_victim    = r_fifo_ptr;
    w_all_valid = 1'b1;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!bus.ts_valid_vector[i]) begin
        w_victim    = WAY_W'(i);
        w_all_valid = 1'b0;
      end
    end
  end

  assign w_victim_dirty = bus.ts_valid_vector[w_victim] && bus.ts_dirty_vector[w_victim];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= 1'b0;
      r_dirty    <= 1'b0;
      r_hit      <= 1'b0;
      r_use_fifo <= 1'b0;
      r_tag      <= '0;
      r_way      <= '0;
      r_fifo_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op    <= bus.req_op;
            r_tag   <= bus.req_tag;
            r_dirty <= bus.req_dirty;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (bus.ts_hit) begin
            r_way      <= bus.ts_hit_way;
            r_hit      <= 1'b1;
            r_use_fifo <= 1'b0;
            r_state    <= r_op ? S_WRITE : S_CLEAR;
          end else if (!r_op) begin
            r_way   <= '0;
            r_hit   <= 1'b0;
            r_state <= S_RESP;
          end else begin
            r_way      <= w_victim;
            r_hit      <= 1'b0;
            r_use_fifo <= w_all_valid;
            r_state    <= w_victim_dirty ? S_WB : S_WRITE;
          end
        end
        S_CLEAR: r_state <= S_RESP;
        S_WB:    if (bus.wb_ready) r_state <= S_WRITE;
        S_WRITE: begin
          if (r_use_fifo) r_fifo_ptr <= r_fifo_ptr + 1'b1;
          r_state <= r_dirty ? S_DSET : S_RESP;
        end
        S_DSET:  r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (r_state == S_IDLE) && !rst;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.resp_valid     = (r_state == S_RESP);
  assign bus.resp_hit       = (r_state == S_RESP) && r_hit;
  assign bus.resp_way       = (r_state == S_RESP) ? r_way : '0;
  assign bus.ts_lookup_en   = (r_state == S_LOOKUP);
  assign bus.ts_write_en    = (r_state == S_WRITE);
  assign bus.ts_read_en     = 1'b0;
  assign bus.ts_valid_clear = (r_state == S_CLEAR);
  assign bus.ts_dirty_set   = (r_state == S_DSET);
  assign bus.ts_tag         = (r_state == S_LOOKUP || r_state == S_WRITE) ? r_tag : '0;
  assign bus.ts_way         = (r_state == S_CLEAR || r_state == S_WRITE || r_state == S_DSET) ? r_way : '0;
  assign bus.wb_valid       = (r_state == S_WB);
  assign bus.wb_way         = (r_state == S_WB) ? r_way : '0;

`ifdef VC_STATS_EN
  logic [15:0] r_stat_hits;
  logic [15:0] r_stat_misses;
  logic [15:0] r_stat_wbs;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_wbs    <= '0;
    end else begin
      if (r_state == S_RESP && !r_op) begin
        if (r_hit) r_stat_hits   <= sat_inc(r_stat_hits);
        else       r_stat_misses <= sat_inc(r_stat_misses);
      end
      if (r_state == S_WB && bus.wb_ready) r_stat_wbs <= sat_inc(r_stat_wbs);
    end
  end

  assign bus.stat_hits   = r_stat_hits;
  assign bus.stat_misses = r_stat_misses;
  assign bus.stat_wbs    = r_stat_wbs;
`else
  assign bus.stat_hits   = '0;
  assign bus.stat_misses = '0;
  assign bus.stat_wbs    = '0;
`endif
endmodule
